// File: rtl/e_mdu.sv
// e_mdu: E-stage multiply/divide unit with architectural HI/LO, multi-cycle MULT/DIV and MT/MF access.
// Define MDU_MADD_EN to enable MADD/MADDU/MSUB/MSUBU accumulate ops; otherwise ops 9-12 act as NONE.
module e_mdu #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [3:0]  mdu_op,
  input  logic [31:0] rs_data,
  input  logic [31:0] rt_data,
  input  logic        req,
  output logic        busy,
  output logic [31:0] mdu_rd,
  output logic [31:0] hi,
  output logic [31:0] lo
);
  typedef enum logic {IDLE, BUSY} state_t;
  state_t state, n_state;
  logic [31:0] cnt, t_hi, t_lo, qs, rs_, qu, ru;
  logic signed [31:0] sa, sdn;
  logic [63:0] sp, up, acc, n_res;
  logic t_wr, n_wr, accept, is_mul, is_div, go, done, ovf;
  assign accept = start & ~req & (state == IDLE);
  assign is_div = (mdu_op == 4'd3) | (mdu_op == 4'd4);
  assign go = accept & (is_mul | is_div);
  always_comb begin
    sp = $signed({{32{rs_data[31]}}, rs_data}) * $signed({{32{rt_data[31]}}, rt_data});
    up = {32'b0, rs_data} * {32'b0, rt_data};
`ifdef MDU_MADD_EN
    is_mul = mdu_op inside {4'd1, 4'd2, 4'd9, 4'd10, 4'd11, 4'd12};
    acc = mdu_op == 4'd9  ? {hi, lo} + sp :
          mdu_op == 4'd10 ? {hi, lo} + up :
          mdu_op == 4'd11 ? {hi, lo} - sp : {hi, lo} - up;
`else
    is_mul = (mdu_op == 4'd1) | (mdu_op == 4'd2);
    acc = 64'h0;
`endif
  end
  // Substitute a divisor of 1 for /0 (result discarded) and INT_MIN/-1 (yields INT_MIN rem 0).
  always_comb begin
    ovf = (rs_data == 32'h8000_0000) & (rt_data == 32'hFFFF_FFFF);
    sa = rs_data;
    sdn = (rt_data == 32'h0 || ovf) ? 32'sd1 : rt_data;
    qs = sa / sdn;
    rs_ = sa % sdn;
    qu = rs_data / ((rt_data == 32'h0) ? 32'd1 : rt_data);
    ru = rs_data % ((rt_data == 32'h0) ? 32'd1 : rt_data);
    n_res = mdu_op == 4'd1 ? sp :
            mdu_op == 4'd2 ? up :
            mdu_op == 4'd3 ? {rs_, qs} :
            mdu_op == 4'd4 ? {ru, qu} : acc;
    n_wr = ~is_div | (rt_data != 32'h0);
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) state <= IDLE;
    else state <= n_state;
  always_comb n_state = state == IDLE ? (go ? BUSY : IDLE) : (cnt == 32'd1 ? IDLE : BUSY);
  always_comb begin
    busy = state == BUSY;
    done = (state == BUSY) & (cnt == 32'd1);
    mdu_rd = mdu_op == 4'd5 ? hi : mdu_op == 4'd6 ? lo : 32'h0;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      cnt <= 32'h0;
      t_hi <= 32'h0;
      t_lo <= 32'h0;
      t_wr <= 1'b0;
      hi <= 32'h0;
      lo <= 32'h0;
    end else begin
      if (go) begin
        cnt <= is_mul ? 32'(MULT_CYCLES) : 32'(DIV_CYCLES);
        {t_hi, t_lo} <= n_res;
        t_wr <= n_wr;
      end else if (busy) cnt <= cnt - 32'd1;
      if (done && t_wr) begin
        hi <= t_hi;
        lo <= t_lo;
      end
      if (accept && mdu_op == 4'd7) hi <= rs_data;
      if (accept && mdu_op == 4'd8) lo <= rs_data;
    end
endmodule

// File: tb/tb_e_mdu.sv
// tb_e_mdu: scoreboard bench for e_mdu; expected HI/LO/busy-length pushed at issue, popped at completion.
module tb_e_mdu;
  logic clk = 0, reset = 1, start = 0, req = 0;
  logic [3:0] mdu_op = 0;
  logic [31:0] rs_data = 0, rt_data = 0;
  logic busy;
  logic [31:0] mdu_rd, hi, lo;
  int errors = 0, checks = 0;
  logic [95:0] sb_q[$];
  logic [63:0] p;
  logic [31:0] a, b, exp_lo;
  always #5 clk = ~clk;
  e_mdu dut (.clk(clk), .reset(reset), .start(start), .mdu_op(mdu_op), .rs_data(rs_data),
             .rt_data(rt_data), .req(req), .busy(busy), .mdu_rd(mdu_rd), .hi(hi), .lo(lo));
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic issue(input logic [3:0] op, input logic [31:0] x, input logic [31:0] y, input logic rq);
    start = 1; mdu_op = op; rs_data = x; rt_data = y; req = rq;
    @(posedge clk); #1;
    start = 0; mdu_op = 0; req = 0; rs_data = 32'hDEAD_BEEF; rt_data = 32'h0BAD_F00D;
  endtask
  task automatic finish_op(input string tag, input int n0);
    logic [95:0] e;
    int n;
    n = n0;
    while (busy && n < 200) begin n++; @(posedge clk); #1; end
    e = sb_q.pop_front();
    chk({tag, "_cycles"}, n, e[31:0]);
    chk({tag, "_hi"}, hi, e[95:64]);
    chk({tag, "_lo"}, lo, e[63:32]);
  endtask
  task automatic run(input string tag, input logic [3:0] op, input logic [31:0] x, input logic [31:0] y,
                     input logic [31:0] eh, input logic [31:0] el, input int ec);
    sb_q.push_back({eh, el, 32'(ec)});
    issue(op, x, y, 0);
    finish_op(tag, 0);
  endtask
  always @(negedge clk)
    if (start && busy && mdu_op inside {4'd1, 4'd2, 4'd3, 4'd4}) chk("start_while_busy", 1, 0);
  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end
  initial begin
    repeat (2) @(posedge clk);
    #1 reset = 0;
    chk("rst_busy", 32'(busy), 0);
    chk("rst_hi", hi, 0);
    chk("rst_lo", lo, 0);
    chk("rst_rd", mdu_rd, 0);
    run("mult", 1, 32'hFFFF_FFFF, 2, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 5);
    run("multu", 2, 32'hFFFF_FFFF, 2, 32'h1, 32'hFFFF_FFFE, 5);
    run("div", 3, 32'hFFFF_FFF9, 2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 10);
    run("divu_zero", 4, 7, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 10);
    run("div_ovf", 3, 32'h8000_0000, 32'hFFFF_FFFF, 0, 32'h8000_0000, 10);
    run("div_neg", 3, 7, 32'hFFFF_FFFE, 1, 32'hFFFF_FFFD, 10);
    run("divu", 4, 100, 7, 2, 14, 10);
    for (int i = 0; i < 4; i++) begin
      a = $urandom; b = $urandom;
      p = i[0] ? {32'b0, a} * {32'b0, b} : longint'($signed(a)) * longint'($signed(b));
      run(i[0] ? "rnd_multu" : "rnd_mult", i[0] ? 4'd2 : 4'd1, a, b, p[63:32], p[31:0], 5);
    end
    issue(1, 3, 3, 1);
    chk("req_mult_busy", 32'(busy), 0);
    repeat (6) @(posedge clk);
    #1;
    chk("req_mult_hi", hi, p[63:32]);
    chk("req_mult_lo", lo, p[31:0]);
    issue(7, 32'h55, 0, 1);
    chk("req_mthi", hi, p[63:32]);
    run("mthi", 7, 32'h1234, 0, 32'h1234, p[31:0], 0);
    mdu_op = 5; #1 chk("mfhi", mdu_rd, 32'h1234);
    mdu_op = 6; #1 chk("mflo", mdu_rd, p[31:0]);
    mdu_op = 0; #1 chk("mf_none", mdu_rd, 0);
    @(posedge clk); #1;
    sb_q.push_back({32'h0, 32'd15, 32'd5});
    issue(1, 3, 5, 0);
    mdu_op = 5; #1 chk("mfhi_busy", mdu_rd, 32'h1234);
    mdu_op = 0;
    issue(8, 9, 0, 0);
    finish_op("mtlo_busy", 1);
    issue(1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
    @(posedge clk); #3 reset = 1;
    #1;
    chk("async_rst_busy", 32'(busy), 0);
    chk("async_rst_hi", hi, 0);
    chk("async_rst_lo", lo, 0);
    @(posedge clk); #1 reset = 0;
    repeat (8) @(posedge clk);
    #1;
    chk("post_rst_busy", 32'(busy), 0);
    chk("post_rst_hi", hi, 0);
    chk("post_rst_lo", lo, 0);
    run("mtlo5", 8, 5, 0, 0, 5, 0);
`ifdef MDU_MADD_EN
    run("madd", 9, 3, 4, 0, 17, 5);
    exp_lo = 17;
`else
    run("madd_off", 9, 3, 4, 0, 5, 0);
    exp_lo = 5;
`endif
    run("op13", 13, 1, 1, 0, exp_lo, 0);
    run("op0", 0, 1, 1, 0, exp_lo, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
